// File: rtl/pipe_ctrl_pkg.sv
// Shared latch-control encodings and FSM state type for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] CTR_RUN    = 2'b00;
  localparam logic [1:0] CTR_SQUASH = 2'b01;
  localparam logic [1:0] CTR_STALL  = 2'b10;
  localparam logic [1:0] CTR_BUBBLE = 2'b11;

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_e;

endpackage

// File: rtl/mul_stall_timer.sv
// RUN/MUL stall sequencer for multicycle EX ops; freeze holds state and count.
module mul_stall_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_STALL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_mul,
  input  logic freeze,
  output logic mulbusy
);

  localparam int CW = $clog2(MUL_STALL + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mulbusy = 1'b0;
    unique case (state_q)
      RUN: begin
        mulbusy = ex_mul;
        if (ex_mul && !freeze) begin
          state_d = MUL;
          cnt_d   = CW'(MUL_STALL - 1);
        end
      end
      MUL: begin
        // cnt==0 is the release cycle: ex_mul is ignored here.
        mulbusy = (cnt_q != '0);
        if (!freeze) begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else             state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: priority mux over memwait, mulbusy,
// mispredict and load-use, plus stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_STALL = 3,
  parameter int REG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mul,
  input  logic             ex_mispredict,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       ctr_ifid,
  output logic [1:0]       ctr_idex,
  output logic [1:0]       ctr_exmem,
  output logic [1:0]       ctr_memwb,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush
);

  logic        memwait, loaduse, mulbusy, flush_evt;
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  assign memwait = mem_req & ~mem_ready;
  assign loaduse = ex_is_load & (ex_rd != '0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  mul_stall_timer #(.MUL_STALL(MUL_STALL)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ex_mul  (ex_mul),
    .freeze  (memwait),
    .mulbusy (mulbusy)
  );

  always_comb begin
    ctr_ifid    = CTR_RUN;
    ctr_idex    = CTR_RUN;
    ctr_exmem   = CTR_RUN;
    ctr_memwb   = CTR_RUN;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    flush_evt   = 1'b0;
    if (!rst) begin
      ctr_ifid  = CTR_SQUASH;
      ctr_idex  = CTR_SQUASH;
      ctr_exmem = CTR_SQUASH;
      ctr_memwb = CTR_SQUASH;
      pc_stall  = 1'b1;
    end else if (memwait) begin
      ctr_ifid  = CTR_STALL;
      ctr_idex  = CTR_STALL;
      ctr_exmem = CTR_STALL;
      ctr_memwb = CTR_SQUASH;
      pc_stall  = 1'b1;
    end else if (mulbusy) begin
      ctr_ifid  = CTR_STALL;
      ctr_idex  = CTR_STALL;
      ctr_exmem = CTR_SQUASH;
      pc_stall  = 1'b1;
    end else if (ex_mispredict) begin
      // ID holds a wrong-path instruction, so any load-use match is moot.
      ctr_ifid    = CTR_SQUASH;
      ctr_idex    = CTR_SQUASH;
      pc_redirect = 1'b1;
      flush_evt   = 1'b1;
    end else if (loaduse) begin
      ctr_ifid = CTR_STALL;
      ctr_idex = CTR_SQUASH;
      pc_stall = 1'b1;
    end
  end

  assign perf_stall_d = perf_stall_q + {31'b0, pc_stall};
  assign perf_flush_d = perf_flush_q + {31'b0, flush_evt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with MUL_STALL=3.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;

  // {ifid, idex, exmem, memwb, pc_stall, pc_redirect}
  localparam logic [9:0] C_IDLE = 10'b00_00_00_00_0_0;
  localparam logic [9:0] C_RST  = 10'b01_01_01_01_1_0;
  localparam logic [9:0] C_MEMW = 10'b10_10_10_01_1_0;
  localparam logic [9:0] C_MULB = 10'b10_10_01_00_1_0;
  localparam logic [9:0] C_FLSH = 10'b01_01_00_00_0_1;
  localparam logic [9:0] C_LU   = 10'b10_01_00_00_1_0;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_mul, ex_mispredict;
  logic             mem_req, mem_ready;
  logic [1:0]       ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb;
  logic             pc_stall, pc_redirect;
  logic [31:0]      perf_stall, perf_flush;
  logic [9:0]       ctl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_STALL(3), .REG_W(REG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_mul        (ex_mul),
    .ex_mispredict (ex_mispredict),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .ctr_ifid      (ctr_ifid),
    .ctr_idex      (ctr_idex),
    .ctr_exmem     (ctr_exmem),
    .ctr_memwb     (ctr_memwb),
    .pc_stall      (pc_stall),
    .pc_redirect   (pc_redirect),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
  );

  assign ctl = {ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb, pc_stall, pc_redirect};

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check control outputs mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check_vec(tag, {22'b0, ctl}, {22'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_is_load = 0; ex_mul = 0; ex_mispredict = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_loaduse_rs2();
    ex_is_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
    id_rs1 = 5'd3; id_use_rs1 = 1;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    check_vec("rst_ctl",   {22'b0, ctl}, {22'b0, C_RST});
    check_vec("rst_pstall", perf_stall, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_vec("idle_pstall", perf_stall, 32'd0);
    cyc("idle_ctl", C_IDLE);

    // Load-use on rs2: one stall cycle, then load has moved on.
    set_loaduse_rs2();
    cyc("lu_rs2", C_LU);
    idle_in();
    cyc("lu_after", C_IDLE);
    check_vec("lu_pstall", perf_stall, 32'd1);

    // x0 destination never creates a dependency.
    ex_is_load = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1; id_use_rs1 = 1;
    cyc("lu_x0", C_IDLE);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; id_rs2 = 5'd1;
    cyc("lu_rs1", C_LU);
    id_use_rs1 = 0;
    cyc("lu_rs1_unused", C_IDLE);
    idle_in();
    check_vec("lu2_pstall", perf_stall, 32'd2);

    // Multicycle op: 3 stalls then release with ex_mul still high.
    ex_mul = 1;
    cyc("mul_s1", C_MULB);
    cyc("mul_s2", C_MULB);
    cyc("mul_s3", C_MULB);
    cyc("mul_rel", C_IDLE);
    ex_mul = 0;
    cyc("mul_after", C_IDLE);
    check_vec("mul_pstall", perf_stall, 32'd5);

    // Memwait in the middle of a multicycle op freezes the count.
    ex_mul = 1;
    cyc("mw_mul_s1", C_MULB);
    mem_req = 1; mem_ready = 0;
    cyc("mw_w1", C_MEMW);
    cyc("mw_w2", C_MEMW);
    mem_ready = 1;
    cyc("mw_mul_s2", C_MULB);
    mem_req = 0; mem_ready = 0;
    cyc("mw_mul_s3", C_MULB);
    cyc("mw_rel", C_IDLE);
    ex_mul = 0;
    check_vec("mw_pstall", perf_stall, 32'd10);

    // Mispredict outranks load-use.
    set_loaduse_rs2();
    ex_mispredict = 1;
    cyc("mp_lu", C_FLSH);
    idle_in();
    check_vec("mp_pflush", perf_flush, 32'd1);
    check_vec("mp_pstall", perf_stall, 32'd10);

    // Mispredict under memwait: redirect only once memory completes.
    ex_mispredict = 1; mem_req = 1; mem_ready = 0;
    cyc("mpw_w1", C_MEMW);
    cyc("mpw_w2", C_MEMW);
    mem_ready = 1;
    cyc("mpw_go", C_FLSH);
    idle_in();
    cyc("mpw_after", C_IDLE);
    check_vec("mpw_pflush", perf_flush, 32'd2);
    check_vec("mpw_pstall", perf_stall, 32'd12);

    // Release cycle evaluates lower-priority hazards normally.
    ex_mul = 1;
    set_loaduse_rs2();
    cyc("rl_s1", C_MULB);
    cyc("rl_s2", C_MULB);
    cyc("rl_s3", C_MULB);
    cyc("rl_rel_lu", C_LU);
    idle_in();
    check_vec("rl_pstall", perf_stall, 32'd16);

    // Asynchronous reset mid-MUL with cnt=2 clears state and counters.
    ex_mul = 1;
    cyc("rm_s1", C_MULB);
    ex_mul = 0;
    rst = 1'b0;
    @(negedge clk);
    check_vec("rm_ctl",    {22'b0, ctl}, {22'b0, C_RST});
    check_vec("rm_pstall", perf_stall, 32'd0);
    check_vec("rm_pflush", perf_flush, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("rm_idle1", C_IDLE);
    cyc("rm_idle2", C_IDLE);
    check_vec("rm_pstall2", perf_stall, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage core. Each cycle it generates the 2-bit control code for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches, plus PC stall and redirect. It resolves four hazard sources:
- data-memory wait
- multicycle EX operations
- branch mispredicts resolved in EX
- load-use dependencies

It also keeps stall and flush performance counters.

## Interface
Parameters:
- MUL_STALL, 3, stall cycles inserted per multicycle EX op (legal range ≥1)
- REG_W, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_mul  in  1  EX holds a multicycle op (level, held while the op sits in EX)
- ex_mispredict  in  1  branch in EX resolved opposite to the prediction
- mem_req, mem_ready  in  1  data-memory request in MEM / request completes this cycle
- ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb  out  2  latch control: 00 run, 01 squash, 10 stall (11 never emitted)
- pc_stall  out  1  hold PC
- pc_redirect  out  1  load PC from the branch target
- perf_stall  out  32  cycles with pc_stall=1
- perf_flush  out  32  count of mispredict flushes

## Operation
- States: RUN, MUL. Down-counter cnt, width $clog2(MUL_STALL+1).
- Derived conditions:
  - memwait = mem_req & ~mem_ready
  - loaduse = ex_is_load & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - mulbusy = (RUN & ex_mul) | (MUL & cnt≠0)
- Priority, highest first; outputs are combinational from state, cnt and inputs. Outputs are listed as ifid/idex/exmem/memwb.
  1. memwait: 10/10/10/01, pc_stall=1. State and cnt frozen.
  2. mulbusy: 10/10/01/00, pc_stall=1.
  3. ex_mispredict: 01/01/00/00, pc_redirect=1, pc_stall=0. perf_flush increments.
  4. loaduse: 10/01/00/00, pc_stall=1.
  5. otherwise: 00/00/00/00, pc_stall=0, pc_redirect=0.
- FSM transitions (only when memwait=0):
  - RUN & ex_mul → MUL, with cnt ← MUL_STALL-1.
  - MUL & cnt≠0 → stay in MUL, cnt ← cnt-1.
  - MUL & cnt==0 → RUN. This is the release cycle: ex_mul is ignored, and items 3–5 are evaluated normally.
- perf_stall increments on every cycle with pc_stall=1 outside reset. Both perf counters wrap modulo 2^32.
- The instruction in ID on a mispredict cycle is wrong-path, so loaduse is not acted on.

## Timing
- Reset (rst=0, asynchronous):
  - state=RUN, cnt=0, perf_stall=0, perf_flush=0
  - all ctr_* = 01, pc_stall=1, pc_redirect=0
- First cycle after rst deasserts: normal evaluation.
- Zero-latency control: ctr_* and pc_* are valid in the same cycle as their inputs. The latches consume them at the next edge.
- A multicycle op produces exactly MUL_STALL stall cycles (first cycle in RUN, the rest in MUL), followed by one release cycle. Any memwait cycles add to the total without consuming cnt.
- A load-use stall is exactly 1 cycle: the bubble moves the load to MEM, so loaduse deasserts.
- A mispredict held under memwait or mulbusy is acted on once, in the first cycle both conditions clear. perf_flush counts it once.
- Simultaneous memwait and mispredict: memwait only. pc_redirect=0 until memwait clears.
- Reset asserted mid-MUL: returns to RUN immediately. cnt is cleared.

## Structure
- Package pipe_ctrl_pkg holds:
  - CTR_RUN=2'b00, CTR_SQUASH=2'b01, CTR_STALL=2'b10, CTR_BUBBLE=2'b11 (reserved)
  - the state enum {RUN, MUL}
- Sub-module mul_stall_timer: RUN/MUL FSM, cnt, freeze input (memwait), outputs mulbusy.
- The top level holds the hazard compare, the priority mux and the perf counters.

## Test plan
- Reset: rst low mid-operation with cnt=2 → ctr_* = 01, pc_stall=1, perf_stall=0. After release with idle inputs: all 00.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle of 10/01/00/00 with pc_stall=1.
- ex_rd=0, same pattern otherwise → no stall.
- Multicycle with MUL_STALL=3: ex_mul held high → exactly 3 cycles of 10/10/01/00, then a release cycle of 00/00/00/00. perf_stall=3.
- Memwait during MUL (after 1 stall cycle): mem_req=1, mem_ready=0 for 2 cycles → 10/10/10/01 for those 2 cycles, then 2 more mulbusy cycles. Total stall count = 5.
- Mispredict with simultaneous loaduse → 01/01/00/00, pc_redirect=1, pc_stall=0, perf_flush=1.
- Mispredict during memwait → no redirect until mem_ready. Redirect appears exactly once afterwards.
